// File: rtl/shift_add_mul_if.sv
// Start/done handshake bundle for the sequential shift-and-add multiplier.
// The master drives the request and operands; the slave returns the result and status.
interface shift_add_mul_if #(
    parameter int n = 8
);
    logic           start;
    logic [n-1:0]   x;
    logic [n-1:0]   y;
    logic [2*n-1:0] product;
    logic           done;
    logic           busy;

    modport master (output start, x, y, input product, done, busy);
    modport slave  (input start, x, y, output product, done, busy);
endinterface

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier: product = x * y, retiring two multiplier bits per clock.
// Companion to the restoring divider; same start/done handshake.
module shift_add_mul #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           reset,
    shift_add_mul_if.slave bus
);
    localparam int CW = $clog2(n / 2);
    localparam logic [CW-1:0] LAST = CW'(n / 2 - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [2*n-1:0] acc;
    logic [2*n-1:0] mcand;
    logic [n-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic [2*n-1:0] addend;
    logic [2*n-1:0] acc_next;

    // Radix-4 digit selects 0, 1, 2 or 3 times the current multiplicand.
    always_comb begin
        addend = '0;
        case (mplier[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = mcand;
            2'd2:    addend = mcand << 1;
            default: addend = (mcand << 1) + mcand;
        endcase
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            bus.product <= '0;
            bus.done    <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand    <= {{n{1'b0}}, bus.x};
                        mplier   <= bus.y;
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        bus.done <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    cnt    <= cnt + CW'(1);
                    // Publish the sum including this cycle's digit; start is ignored here.
                    if (cnt == LAST) begin
                        bus.product <= acc_next;
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mul.sv
// Randomised scoreboard bench for shift_add_mul (n=8) against a cycle-level behavioural model.
module tb_shift_add_mul;
    localparam int N = 8;
    localparam int LAT = N / 2;

    typedef struct {
        logic [2*N-1:0] p;
        int             due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    shift_add_mul_if #(.n(N)) bus ();

    shift_add_mul #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    exp_t           exp_q[$];
    int             cycle = 0;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [2*N-1:0] m_product = '0;
    logic [2*N-1:0] m_pending = '0;
    int             m_left = 0;
    logic           prev_done = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    // Reference model: an operation is a product computed with plain arithmetic, due LAT clocks after acceptance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_product = '0;
            m_left    = 0;
            exp_q.delete();
        end else begin
            cycle++;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy    = 1'b0;
                    m_done    = 1'b1;
                    m_product = m_pending;
                end
            end else if (bus.start) begin
                exp_t e;
                m_busy    = 1'b1;
                m_done    = 1'b0;
                m_left    = LAT;
                m_pending = {{N{1'b0}}, bus.x} * {{N{1'b0}}, bus.y};
                e.p       = m_pending;
                e.due     = cycle + LAT;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: pops the scoreboard on every rising done and cross-checks status each cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            check_output("busy", 32'(bus.busy), 32'(m_busy));
            check_output("done", 32'(bus.done), 32'(m_done));
            check_output("product_hold", 32'(bus.product), 32'(m_product));
            if (bus.done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no result at cycle %0d", cycle);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("result", 32'(bus.product), 32'(e.p));
                    check_output("latency", 32'(cycle), 32'(e.due));
                    check_output("busy_at_done", 32'(bus.busy), 32'(0));
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = N'($urandom);
        bus.y     = N'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 20; k++) begin
            if (!m_busy) break;
            @(negedge clk);
        end
        if (m_busy) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: got busy after %0d cycles, expected idle", k);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (2) @(negedge clk);
        check_output("reset_product", 32'(bus.product), 32'(0));
        check_output("reset_done", 32'(bus.done), 32'(0));
        check_output("reset_busy", 32'(bus.busy), 32'(0));
        reset = 1'b0;

        apply_stimulus(8'd13, 8'd11);
        wait_idle();
        repeat (3) @(negedge clk);
        check_output("13x11_held", 32'(bus.product), 32'h008F);

        apply_stimulus(8'd255, 8'd255);
        wait_idle();
        check_output("255x255", 32'(bus.product), 32'hFE01);
        apply_stimulus(8'd0, 8'd200);
        wait_idle();
        apply_stimulus(8'd200, 8'd0);
        wait_idle();
        check_output("200x0", 32'(bus.product), 32'(0));

        // A second request during RUN must be ignored entirely.
        apply_stimulus(8'd7, 8'd9);
        bus.start = 1'b1;
        bus.x     = 8'd100;
        bus.y     = 8'd100;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check_output("7x9_no_restart", 32'(bus.product), 32'h003F);

        // Asynchronous reset in the middle of a run.
        apply_stimulus(8'd50, 8'd3);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_output("async_product", 32'(bus.product), 32'(0));
        check_output("async_done", 32'(bus.done), 32'(0));
        check_output("async_busy", 32'(bus.busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        apply_stimulus(8'd6, 8'd7);
        wait_idle();
        check_output("6x7", 32'(bus.product), 32'(42));

        // Start held high: back-to-back operations, y changed before the second capture.
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 8'd3;
        bus.y     = 8'd5;
        repeat (LAT + 1) @(negedge clk);
        check_output("held_first", 32'(bus.product), 32'(15));
        bus.y = 8'd6;
        @(negedge clk);
        check_output("held_restart_busy", 32'(bus.busy), 32'(1));
        bus.start = 1'b0;
        wait_idle();
        check_output("held_second", 32'(bus.product), 32'(18));

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(N'($urandom), N'($urandom));
            if ($urandom_range(0, 2) != 0) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check_output("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
